// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types, constants and the round-robin index helper for the UART
// transmit arbiter.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        GAP
    } arb_state_t;

    localparam int BYTE_WIDTH = 8;

    // Client index reached by stepping 'offset' places past 'pointer', wrapping at 'num'.
    function automatic int next_rr_index(input int pointer, input int offset, input int num);
        return (pointer + offset) % num;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: finds the first asserted request
// strictly after 'pointer', wrapping around the request vector.
module rr_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    localparam int IW = $clog2(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] req,
    input  logic [IW-1:0]             pointer,
    output logic                      found,
    output logic [IW-1:0]             index
);

    always_comb begin
        int candidate;
        // NOTE: every output gets a default before the loop so no latch is inferred.
        found     = 1'b0;
        index     = '0;
        candidate = 0;
        for (int offset = 1; offset <= NUM_REQUESTERS; offset++) begin
            candidate = next_rr_index(int'(pointer), offset, NUM_REQUESTERS);
            if (!found && req[candidate[IW-1:0]]) begin
                found = 1'b1;
                index = candidate[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter write
// port among NUM_REQUESTERS byte-stream clients.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int MAX_BURST      = 16,
    localparam int IW = $clog2(NUM_REQUESTERS)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_REQUESTERS-1:0]            req_valid,
    input  logic [NUM_REQUESTERS*BYTE_WIDTH-1:0] req_data,
    input  logic [NUM_REQUESTERS-1:0]            req_last,
    output logic [NUM_REQUESTERS-1:0]            req_ready,
    input  logic                                 tx_buffer_full,
    output logic [BYTE_WIDTH-1:0]                tx_data_in,
    output logic                                 tx_write_enable,
    output logic [IW-1:0]                        grant_id,
    output logic                                 busy
);

    arb_state_t            state;
    logic [IW-1:0]         rr_pointer;
    logic [7:0]            burst_count;
    logic                  packet_done;
    logic                  pick_found;
    logic [IW-1:0]         pick_index;
    logic                  accept;
    logic [BYTE_WIDTH-1:0] client_byte [NUM_REQUESTERS];

    for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_unpack
        assign client_byte[i] = req_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end

    rr_picker #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_picker (
        .req     (req_valid),
        .pointer (rr_pointer),
        .found   (pick_found),
        .index   (pick_index)
    );

    // Ready follows buffer_full in the same cycle so a full buffer never sees a write.
    always_comb begin
        req_ready = '0;
        if (state == GRANTED) begin
            req_ready[grant_id] = !tx_buffer_full;
        end
    end

    assign accept = (state == GRANTED) && req_valid[grant_id] && !tx_buffer_full;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            rr_pointer      <= IW'(NUM_REQUESTERS - 1);
            burst_count     <= '0;
            packet_done     <= 1'b0;
            grant_id        <= '0;
            busy            <= 1'b0;
            tx_data_in      <= '0;
            tx_write_enable <= 1'b0;
        end else begin
            tx_write_enable <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id    <= pick_index;
                        busy        <= 1'b1;
                        burst_count <= '0;
                        state       <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (accept) begin
                        tx_data_in      <= client_byte[grant_id];
                        tx_write_enable <= 1'b1;
                        burst_count     <= burst_count + 8'd1;
                        packet_done     <= req_last[grant_id];
                        state           <= GAP;
                    end
                end
                GAP: begin
                    // Releasing moves the pointer onto this client so it is scanned last.
                    if (packet_done || burst_count == 8'(MAX_BURST)) begin
                        rr_pointer <= grant_id;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        state <= GRANTED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
